// File: rtl/nf_reg_file_sb.sv
// nanoFOX register file: combinational multi-port reads with writeback bypass,
// a post-reset clear sweep, and a pending-write scoreboard for RAW hazard detection.
module nf_reg_file_sb #(
  parameter int XLEN     = 32,
  parameter int REG_NUM  = 32,
  parameter int RD_PORTS = 2,
  parameter int R0_ZERO  = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(REG_NUM)
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [RD_PORTS-1:0][AW-1:0]        ra_i,
  output logic [RD_PORTS-1:0][XLEN-1:0]      rd_o,
  output logic [RD_PORTS-1:0]                hazard_o,
  input  logic [AW-1:0]                      wa3_i,
  input  logic [XLEN-1:0]                    wd3_i,
  input  logic                               we3_i,
  input  logic                               set_en_i,
  input  logic [AW-1:0]                      set_addr_i,
  input  logic [AW-1:0]                      ra0_i,
  output logic [XLEN-1:0]                    rd0_o,
  output logic                               init_busy_o
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam logic [AW:0]   REG_LIM  = (AW + 1)'(REG_NUM);
  localparam logic [AW-1:0] LAST_IDX = AW'(REG_NUM - 1);

  state_e                 state_q, state_d;
  logic [AW-1:0]          clr_idx_q, clr_idx_d;
  logic [REG_NUM-1:0]     pend_q, pend_d;
  logic [XLEN-1:0]        regs_q [REG_NUM];

  logic                   run;
  logic                   clr_we;
  logic                   wr_en;
  logic                   set_ok;
  logic [RD_PORTS-1:0]    byp;

  // Address names a real, writable register (in range and not the hardwired zero).
  function automatic logic addr_live(input logic [AW-1:0] a);
    return ({1'b0, a} < REG_LIM) && !((R0_ZERO != 0) && (a == '0));
  endfunction

  assign run    = (state_q == ST_RUN) && !reset_i;
  assign wr_en  = run && we3_i && addr_live(wa3_i);
  assign set_ok = run && set_en_i && addr_live(set_addr_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    clr_we      = 1'b0;
    init_busy_o = 1'b1;
    case (state_q)
      ST_CLEAR: begin
        clr_we    = !reset_i;
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == LAST_IDX) begin
          state_d   = ST_RUN;
          clr_idx_d = '0;
        end
      end
      ST_RUN: begin
        init_busy_o = reset_i;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // NOTE: the array has no reset branch on purpose; the sweep clears it one entry
  // per cycle, which keeps the storage a plain RAM-style structure.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      regs_q[clr_idx_q] <= '0;
    end else if (wr_en) begin
      regs_q[wa3_i] <= wd3_i;
    end
  end

  // Clear is applied before set so a same-cycle reissue keeps the register pending.
  always_comb begin
    pend_d = pend_q;
    if (wr_en) begin
      pend_d[wa3_i] = 1'b0;
    end
    if (set_ok) begin
      pend_d[set_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_comb begin
    for (int i = 0; i < RD_PORTS; i++) begin
      rd_o[i]     = '0;
      hazard_o[i] = 1'b0;
      byp[i]      = (BYPASS != 0) && we3_i && (wa3_i == ra_i[i]);
      if (run && addr_live(ra_i[i])) begin
        rd_o[i]     = byp[i] ? wd3_i : regs_q[ra_i[i]];
        hazard_o[i] = pend_q[ra_i[i]] && !byp[i];
      end
    end
  end

  always_comb begin
    rd0_o = '0;
    if (run && addr_live(ra0_i)) begin
      rd0_o = regs_q[ra0_i];
    end
  end

endmodule

// File: tb/tb_nf_reg_file_sb.sv
// Self-checking bench for nf_reg_file_sb: expectations are queued when stimulus
// is driven and compared against DUT outputs shortly after each negedge.
module tb_nf_reg_file_sb;

  logic                clk_i;
  logic                reset_i;
  logic [1:0][4:0]     ra_i;
  logic [1:0][31:0]    rd_o;
  logic [1:0]          hazard_o;
  logic [4:0]          wa3_i;
  logic [31:0]         wd3_i;
  logic                we3_i;
  logic                set_en_i;
  logic [4:0]          set_addr_i;
  logic [4:0]          ra0_i;
  logic [31:0]         rd0_o;
  logic                init_busy_o;

  nf_reg_file_sb dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .ra_i        (ra_i),
    .rd_o        (rd_o),
    .hazard_o    (hazard_o),
    .wa3_i       (wa3_i),
    .wd3_i       (wd3_i),
    .we3_i       (we3_i),
    .set_en_i    (set_en_i),
    .set_addr_i  (set_addr_i),
    .ra0_i       (ra0_i),
    .rd0_o       (rd0_o),
    .init_busy_o (init_busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  localparam int SEL_RD0 = 0, SEL_RD1 = 1, SEL_DBG = 2, SEL_HZ = 3, SEL_BUSY = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl [32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic expect_o(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_RD0:  return rd_o[0];
      SEL_RD1:  return rd_o[1];
      SEL_DBG:  return rd0_o;
      SEL_HZ:   return {30'b0, hazard_o};
      SEL_BUSY: return {31'b0, init_busy_o};
      default:  return '0;
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic se, input logic [4:0] sa,
                     input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] dbg);
    @(negedge clk_i);
    we3_i      = we;
    wa3_i      = wa;
    wd3_i      = wd;
    set_en_i   = se;
    set_addr_i = sa;
    ra_i[0]    = r0;
    ra_i[1]    = r1;
    ra0_i      = dbg;
  endtask

  // Releases reset and counts how many consecutive samples show init_busy.
  task automatic release_and_measure(input string tag);
    int n;
    n = 0;
    @(negedge clk_i);
    reset_i = 1'b0;
    #2;
    while (init_busy_o === 1'b1 && n < 100) begin
      n++;
      @(negedge clk_i);
      #2;
    end
    check(tag, n, 32);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_i = 1'b1;
    cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd4, 5'd6, 5'd4);
    expect_o("rst_busy", SEL_BUSY, 32'd1);
    expect_o("rst_rd0", SEL_RD0, 32'd0);
    expect_o("rst_rd1", SEL_RD1, 32'd0);
    expect_o("rst_dbg", SEL_DBG, 32'd0);
    expect_o("rst_hz", SEL_HZ, 32'd0);
    drain();
    release_and_measure("busy_len");

    for (int a = 0; a < 32; a++) begin
      cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'(a), 5'(a), 5'(a));
      expect_o("clr_rd0", SEL_RD0, 32'd0);
      expect_o("clr_rd1", SEL_RD1, 32'd0);
      expect_o("clr_dbg", SEL_DBG, 32'd0);
      expect_o("clr_hz", SEL_HZ, 32'd0);
      drain();
      mdl[a] = '0;
    end

    // Same-cycle bypass versus the non-bypassed debug port.
    cyc(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd5, 5'd1, 5'd5);
    expect_o("byp_rd0", SEL_RD0, 32'hDEAD_BEEF);
    expect_o("byp_dbg_old", SEL_DBG, 32'd0);
    drain();
    cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd5, 5'd5, 5'd5);
    expect_o("wr_dbg", SEL_DBG, 32'hDEAD_BEEF);
    expect_o("wr_rd1", SEL_RD1, 32'hDEAD_BEEF);
    drain();
    mdl[5] = 32'hDEAD_BEEF;

    // Register 0 stays zero and never becomes pending.
    cyc(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    expect_o("r0_same", SEL_RD0, 32'd0);
    expect_o("r0_dbg_same", SEL_DBG, 32'd0);
    drain();
    cyc(1'b0, 5'd0, '0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0);
    expect_o("r0_next", SEL_RD0, 32'd0);
    expect_o("r0_dbg_next", SEL_DBG, 32'd0);
    drain();
    cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    expect_o("r0_hz", SEL_HZ, 32'd0);
    drain();

    // Issue to r7, observe hazard, retire through writeback.
    cyc(1'b0, 5'd0, '0, 1'b1, 5'd7, 5'd7, 5'd7, 5'd7);
    expect_o("set7_same_hz", SEL_HZ, 32'd0);
    drain();
    cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd7, 5'd7, 5'd7);
    expect_o("set7_hz", SEL_HZ, 32'd3);
    drain();
    cyc(1'b1, 5'd7, 32'h0000_0077, 1'b0, 5'd0, 5'd0, 5'd7, 5'd7);
    expect_o("ret7_hz_byp", SEL_HZ, 32'd0);
    expect_o("ret7_rd1", SEL_RD1, 32'h0000_0077);
    expect_o("ret7_dbg", SEL_DBG, 32'd0);
    drain();
    cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd7, 5'd7, 5'd7);
    expect_o("ret7_hz_after", SEL_HZ, 32'd0);
    expect_o("ret7_rd_after", SEL_RD1, 32'h0000_0077);
    drain();
    mdl[7] = 32'h0000_0077;

    // Set and clear of r9 in the same cycle: set wins.
    cyc(1'b0, 5'd0, '0, 1'b1, 5'd9, 5'd0, 5'd9, 5'd9);
    drain();
    cyc(1'b1, 5'd9, 32'h0000_0099, 1'b1, 5'd9, 5'd0, 5'd9, 5'd9);
    expect_o("sc9_hz_byp", SEL_HZ, 32'd0);
    expect_o("sc9_rd1_byp", SEL_RD1, 32'h0000_0099);
    drain();
    cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, 5'd9, 5'd9);
    expect_o("sc9_hz", SEL_HZ, 32'd2);
    expect_o("sc9_rd1", SEL_RD1, 32'h0000_0099);
    expect_o("sc9_dbg", SEL_DBG, 32'h0000_0099);
    drain();
    cyc(1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 5'd0, 5'd9, 5'd9);
    drain();
    cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd9, 5'd9, 5'd9);
    expect_o("ret9_hz", SEL_HZ, 32'd0);
    drain();
    mdl[9] = 32'h0000_0099;

    // Random writes checked against the bench model on both ports.
    for (int k = 0; k < 8; k++) begin
      logic [31:0] d;
      d = $urandom;
      cyc(1'b1, 5'(10 + k), d, 1'b0, 5'd0, 5'd1, 5'd1, 5'd1);
      drain();
      mdl[10 + k] = d;
    end
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'(10 + k), 5'(17 - k), 5'(10 + k));
      expect_o("rnd_rd0", SEL_RD0, mdl[10 + k]);
      expect_o("rnd_rd1", SEL_RD1, mdl[17 - k]);
      expect_o("rnd_dbg", SEL_DBG, mdl[10 + k]);
      drain();
    end

    // Mid-sweep reset: leave r3 and r12 dirty, reset, stop the sweep at index 10.
    cyc(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd12, 5'd0, 5'd0, 5'd0);
    drain();
    cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd3, 5'd12, 5'd3);
    expect_o("pre_rd0", SEL_RD0, 32'h0000_0033);
    expect_o("pre_hz", SEL_HZ, 32'd2);
    drain();
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    #2;
    expect_o("sw_busy", SEL_BUSY, 32'd1);
    expect_o("sw_rd_forced", SEL_RD0, 32'd0);
    expect_o("sw_dbg_forced", SEL_DBG, 32'd0);
    expect_o("sw_hz_forced", SEL_HZ, 32'd0);
    drain();
    repeat (9) @(negedge clk_i);
    cyc(1'b1, 5'd3, 32'h0000_0BAD, 1'b1, 5'd3, 5'd3, 5'd12, 5'd3);
    reset_i = 1'b1;
    expect_o("mid_busy", SEL_BUSY, 32'd1);
    expect_o("mid_rd0", SEL_RD0, 32'd0);
    drain();
    release_and_measure("busy_len_restart");
    we3_i    = 1'b0;
    set_en_i = 1'b0;
    for (int a = 0; a < 32; a++) begin
      cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'(a), 5'(31 - a), 5'(a));
      expect_o("post_rd0", SEL_RD0, 32'd0);
      expect_o("post_dbg", SEL_DBG, 32'd0);
      expect_o("post_hz", SEL_HZ, 32'd0);
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
